// File: rtl/ascii_pkg.sv
// Shared constants and state encoding for the ASCII frame path
// (sequencer, Hamming encoder, correction re-encoder).
package ascii_pkg;

    localparam int NCHAR   = 16;
    localparam int CW      = 7;
    localparam int CODE_W  = 11;
    localparam int IDX_W   = 4;
    localparam int FRAME_W = NCHAR * CW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } seq_state_t;

endpackage

// File: rtl/hamming_enc_11_7.sv
// Hamming(11,7) even-parity encoder; code position 1 is code[10], position 11 is code[0].
module hamming_enc_11_7
    import ascii_pkg::*;
(
    input  logic [CW-1:0]     data,
    output logic [CODE_W-1:0] code
);

    logic d3, d5, d6, d7, d9, d10, d11;
    logic p1, p2, p4, p8;

    assign d3  = data[6];
    assign d5  = data[5];
    assign d6  = data[4];
    assign d7  = data[3];
    assign d9  = data[2];
    assign d10 = data[1];
    assign d11 = data[0];

    assign p1 = d3 ^ d5 ^ d7 ^ d9 ^ d11;
    assign p2 = d3 ^ d6 ^ d7 ^ d10 ^ d11;
    assign p4 = d5 ^ d6 ^ d7;
    assign p8 = d9 ^ d10 ^ d11;

    assign code = {p1, p2, d3, p4, d5, d6, d7, p8, d9, d10, d11};

endmodule

// File: rtl/ascii_frame_sequencer.sv
// Accepts a 16-char 7-bit ASCII frame and streams it MSB char first, one beat per
// character, with the Hamming(11,7) codeword alongside each character.
module ascii_frame_sequencer
    import ascii_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAME_W-1:0] in_frame,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CW-1:0]      out_char,
    output logic [CODE_W-1:0]  out_code,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               busy,
    output logic [7:0]         frames_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);

    seq_state_t         state_q, state_d;
    logic [FRAME_W-1:0] frame_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         done_q, done_d;
    logic               load;
    logic               sending;
    logic [CW-1:0]      cur_char;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (load)
                frame_q <= in_frame;
        end
    end

    // A handshake always wins over abort: the beat is transferred first,
    // and a last-beat handshake completes and counts the frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = done_q + 8'd1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else if (abort) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (abort) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign sending  = (state_q == SEND);
    assign cur_char = frame_q[FRAME_W-1-CW*idx_q -: CW];

    // Beat fields are pure functions of registered state, so they hold
    // steady through back-pressure without any extra output registers.
    assign busy        = sending;
    assign in_ready    = !sending;
    assign out_valid   = sending;
    assign out_char    = sending ? cur_char : '0;
    assign out_idx     = sending ? idx_q : '0;
    assign out_last    = sending && (idx_q == LAST_IDX);
    assign frames_done = done_q;

    hamming_enc_11_7 u_enc (
        .data (out_char),
        .code (out_code)
    );

endmodule

// File: tb/tb_ascii_frame_sequencer.sv
// Directed bench for ascii_frame_sequencer: framing, stalls, abort, async reset, wrap.
module tb_ascii_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [111:0] in_frame;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [6:0]   out_char;
    logic [10:0]  out_code;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic [7:0]   frames_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ascii_frame_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_frame    (in_frame),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_char    (out_char),
        .out_code    (out_code),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .frames_done (frames_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference encoder built from the textbook rule: parity bit 2^k covers
    // every position whose index has bit k set.
    function automatic logic [10:0] ham_ref(input logic [6:0] c);
        logic [11:0] pos;
        logic [10:0] r;
        int          di;
        logic        par;
        pos = '0;
        di  = 6;
        for (int p = 1; p <= 11; p++)
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                pos[p] = c[di];
                di--;
            end
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 11; p++)
                if (((p >> k) & 1) == 1 && p != (1 << k))
                    par = par ^ pos[p];
            pos[1 << k] = par;
        end
        for (int p = 1; p <= 11; p++)
            r[11-p] = pos[p];
        return r;
    endfunction

    function automatic logic [111:0] mk_frame(input logic [6:0] base, input logic [6:0] step);
        logic [111:0] f;
        f = '0;
        for (int k = 0; k < 16; k++)
            f[111-7*k -: 7] = 7'(base + step * 7'(k));
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a frame at a negedge, returns at the negedge after the accept edge.
    task automatic start_frame(input logic [111:0] f, input string tag);
        int budget;
        budget = 0;
        while (!in_ready && budget < 40) begin
            tick();
            budget++;
        end
        chk({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_frame = f;
        tick();
        in_valid = 1'b0;
        in_frame = '0;
    endtask

    task automatic check_beat(input string tag, input logic [6:0] c, input int idx);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(idx));
        chk({tag, "_char"},  32'(out_char),  32'(c));
        chk({tag, "_code"},  32'(out_code),  32'(ham_ref(c)));
        chk({tag, "_last"},  32'(out_last),  32'(idx == 15));
    endtask

    initial begin
        int   exp_idx;
        int   ph;
        logic hs;
        int   m;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_frame  = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_out_char",  32'(out_char),    32'd0);
        chk("rst_out_code",  32'(out_code),    32'd0);
        chk("rst_out_idx",   32'(out_idx),     32'd0);
        chk("rst_out_last",  32'(out_last),    32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_done",      32'(frames_done), 32'd0);
        rst = 1'b0;
        tick();

        // Known codewords worked by hand: 'H' -> 0x190, 'A' -> 0x109.
        chk("ref_H", 32'(ham_ref(7'h48)), 32'h190);
        chk("ref_A", 32'(ham_ref(7'h41)), 32'h109);

        // 16 x 'H', no back-pressure; in_frame is cleared right after accept.
        out_ready = 1'b1;
        start_frame(mk_frame(7'h48, 7'd0), "h");
        chk("h_in_ready_low", 32'(in_ready), 32'd0);
        for (int k = 0; k < 16; k++) begin
            check_beat("h", 7'h48, k);
            chk("h_code_const", 32'(out_code), 32'h190);
            tick();
        end
        chk("h_idle_valid", 32'(out_valid),   32'd0);
        chk("h_idle_ready", 32'(in_ready),    32'd1);
        chk("h_done",       32'(frames_done), 32'd1);
        chk("h_idle_char",  32'(out_char),    32'd0);

        // "ABCDEFGHIJKLMNOP" with out_ready pattern 1,0,0 repeating.
        start_frame(mk_frame(7'h41, 7'd1), "st");
        exp_idx = 0;
        ph      = 0;
        for (int cyc = 0; cyc < 80 && exp_idx < 16; cyc++) begin
            check_beat("st", 7'(7'h41 + exp_idx), exp_idx);
            out_ready = (ph % 3 == 0);
            hs        = out_ready;
            ph++;
            tick();
            if (hs) exp_idx++;
        end
        chk("st_all_beats", 32'(exp_idx),     32'd16);
        chk("st_idle",      32'(out_valid),   32'd0);
        chk("st_done",      32'(frames_done), 32'd2);

        // Abort at idx 5 without a handshake.
        out_ready = 1'b1;
        start_frame(mk_frame(7'h30, 7'd2), "ab5");
        repeat (5) tick();
        chk("ab5_at5", 32'(out_idx), 32'd5);
        out_ready = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab5_valid", 32'(out_valid),   32'd0);
        chk("ab5_busy",  32'(busy),        32'd0);
        chk("ab5_idx",   32'(out_idx),     32'd0);
        chk("ab5_done",  32'(frames_done), 32'd2);

        // Abort while IDLE is ignored: the frame is still accepted.
        abort     = 1'b1;
        out_ready = 1'b1;
        start_frame(mk_frame(7'h61, 7'd1), "nx");
        abort = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_beat("nx", 7'(7'h61 + k), k);
            tick();
        end
        chk("nx_done", 32'(frames_done), 32'd3);

        // Abort together with the last handshake: frame completes.
        start_frame(mk_frame(7'h50, 7'd3), "ab15");
        repeat (15) tick();
        chk("ab15_at15", 32'(out_last), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab15_valid", 32'(out_valid),   32'd0);
        chk("ab15_done",  32'(frames_done), 32'd4);

        // Abort together with idx 3 handshake: stop, no count.
        start_frame(mk_frame(7'h20, 7'd5), "ab3");
        repeat (3) tick();
        chk("ab3_at3", 32'(out_idx), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab3_valid", 32'(out_valid),   32'd0);
        chk("ab3_done",  32'(frames_done), 32'd4);

        // Asynchronous reset at idx 8, sampled before the next rising edge.
        start_frame(mk_frame(7'h41, 7'd1), "ar");
        repeat (8) tick();
        chk("ar_at8", 32'(out_idx), 32'd8);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid),   32'd0);
        chk("ar_busy",  32'(busy),        32'd0);
        chk("ar_ready", 32'(in_ready),    32'd1);
        chk("ar_idx",   32'(out_idx),     32'd0);
        chk("ar_char",  32'(out_char),    32'd0);
        chk("ar_code",  32'(out_code),    32'd0);
        chk("ar_last",  32'(out_last),    32'd0);
        chk("ar_done",  32'(frames_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 256 back-to-back frames with in_valid held high: 17-cycle period.
        in_frame = mk_frame(7'h48, 7'd0);
        in_valid = 1'b1;
        for (int n = 0; n < 256 * 17; n++) begin
            tick();
            m = n % 17;
            chk("b2b_busy",  32'(busy),        32'(m < 16));
            chk("b2b_ready", 32'(in_ready),    32'(m == 16));
            chk("b2b_idx",   32'(out_idx),     32'(m < 16 ? m : 0));
            chk("b2b_done",  32'(frames_done), 32'(((n + 1) / 17) % 256));
        end
        in_valid = 1'b0;
        chk("b2b_wrap", 32'(frames_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ascii_frame_sequencer.md
# ascii_frame_sequencer

Sequences a 112-bit ASCII frame (16 × 7-bit characters) onto a one-character-per-beat stream for the Hamming stage. It accepts a whole frame over a valid/ready handshake and emits characters MSB-first. Each beat carries the raw character and its Hamming(11,7) codeword. The block sits between the frame source and the channel/error-injection path, and uses the same character slicing as the frame-to-ASCII splitter.

## Interface
- `NCHAR`, 16: characters per frame.
- `CW`, 7: bits per character (fixed 7 for Hamming(11,7)).
- Reset is asynchronous and active-high; single clock `clk`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: async active-high reset.
- `in_valid` in 1: frame available.
- `in_ready` out 1: block can accept a frame.
- `in_frame` in NCHAR*CW (112): frame; char k = `in_frame[NCHAR*CW-1-CW*k -: CW]`.
- `abort` in 1: discard remainder of current frame.
- `out_valid` out 1: character beat valid.
- `out_ready` in 1: downstream accepts beat.
- `out_char` out CW: current character.
- `out_code` out 11: Hamming(11,7) codeword of `out_char`.
- `out_idx` out 4: character index 0..NCHAR-1.
- `out_last` out 1: beat is char NCHAR-1.
- `busy` out 1: frame in progress.
- `frames_done` out 8: count of fully sent frames; wraps 255→0.

## Operation
- FSM states: IDLE, SEND.
- IDLE: `in_ready`=1. If `in_valid` is high, latch `in_frame` into the frame register, set idx=0, and go to SEND.
- SEND: `out_valid`=1, `out_char`=char[idx], `out_last`=(idx==NCHAR-1).
  - On `out_valid && out_ready` with idx<NCHAR-1: idx++.
  - On that handshake with idx==NCHAR-1: `frames_done`++ and go to IDLE.
- `abort` is sampled in SEND only; it is ignored in IDLE.
  - Abort moves the FSM to IDLE next cycle. `frames_done` is unchanged.
  - Abort concurrent with a handshake: the beat counts as transferred. If that beat is the last, the frame completes normally, `frames_done` increments, and abort has no further effect.
- Hamming(11,7), even parity, positions 1..11 map to `out_code[10]..out_code[0]`.
  - Data placement: d3=c[6], d5=c[5], d6=c[4], d7=c[3], d9=c[2], d10=c[1], d11=c[0].
  - Parity: p1 = ^{3,5,7,9,11}, p2 = ^{3,6,7,10,11}, p4 = ^{5,6,7}, p8 = ^{9,10,11}.
- Outputs while in IDLE: `out_char`, `out_code`, `out_idx`, `out_last` are 0.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `out_char`=0; `out_code`=0; `out_idx`=0; `out_last`=0; `busy`=0; `frames_done`=0.
- Frame accepted at edge t → first beat valid at t+1.
- With `out_ready` held high: 16 beats on t+1..t+16, IDLE at t+17. Next frame acceptable at t+17; throughput is 17 cycles per frame.
- `out_*` are held stable while `out_valid && !out_ready` (AXI-style; no retraction).
- `out_code` is a combinational function of registered `out_char`; no added latency.
- `in_frame` is sampled only on the accept edge; later changes have no effect.
- `busy` = (state==SEND).
- Reset asserted mid-frame: immediate async return to reset values. The partial frame is lost and not counted.

## Structure
- Shared package `ascii_pkg`: `NCHAR`, `CW`, `CODE_W`=11, state enum {IDLE, SEND}.
- Sub-module `hamming_enc_11_7`: pure combinational, `data[6:0]` → `code[10:0]`. It is reused by the correction path's re-encoder.
- Frame register, index counter, FSM, and `frames_done` counter are in the top module.

## Test plan
- Reset then 16×'H' (0x48) frame, `out_ready`=1 → 16 beats t+1..t+16, `out_char`=0x48, `out_code`=0x190, `out_last` only at idx 15, `frames_done`=1.
- Frame "ABCDEFGHIJKLMNOP" with `out_ready` toggling 1,0,0,1… → chars in order 0x41..0x50; beats stable during stalls; no loss or duplication.
- `abort` during idx 5 with no handshake → IDLE next cycle, `out_valid`=0, `frames_done` unchanged. Next frame starts at idx 0.
- `abort` concurrent with idx 15 handshake → frame completes, `frames_done`+1; concurrent with idx 3 handshake → idx 3 counted, then IDLE.
- `rst` pulsed at idx 8 → all outputs at reset values asynchronously; `frames_done`=0.
- 256 back-to-back frames → `frames_done` wraps to 0; `in_ready` low throughout SEND. `in_valid` held high accepts each frame at the 17-cycle spacing.
